// File: rtl/i_buf_controller_pkg.sv
// Shared definitions for the capture-side linebuffer controller.
// The geometry defaults here are also used by the display-side controller.
package i_buf_controller_pkg;

    localparam int PIXEL_WIDTH = 8;
    localparam int WORD_WIDTH  = 32;
    localparam int COUNT_WIDTH = 13;

    localparam int DEFAULT_DISPLAY_WIDTH  = 640;
    localparam int DEFAULT_DISPLAY_HEIGHT = 320;

    localparam int ERR_OVERRUN    = 0;
    localparam int ERR_SHORT_LINE = 1;

    typedef enum logic [1:0] {
        WAIT_FRAME,
        WAIT_LINE,
        CAPTURE,
        LINE_END
    } state_t;

    // Left-aligns a partial group of pixels and fills the unused low bytes with zeros.
    function automatic logic [WORD_WIDTH-1:0] pad_word(input logic [23:0] sr,
                                                       input logic [1:0]  count);
        logic [WORD_WIDTH-1:0] word;
        case (count)
            2'd1:    word = {sr[7:0],  24'h0};
            2'd2:    word = {sr[15:0], 16'h0};
            2'd3:    word = {sr[23:0], 8'h0};
            default: word = '0;
        endcase
        return word;
    endfunction

endpackage

// File: rtl/i_buf_controller_pixel_packer.sv
// Packs four 8-bit pixels into one 32-bit word, first pixel in the top byte.
// A flush emits any partial group zero-padded in the low bytes.
module i_buf_controller_pixel_packer
    import i_buf_controller_pkg::*;
(
    input  logic                   pclk,
    input  logic                   reset_n,
    input  logic                   clear,
    input  logic                   shift_en,
    input  logic                   flush,
    input  logic [PIXEL_WIDTH-1:0] pixel,
    output logic [WORD_WIDTH-1:0]  word,
    output logic                   word_valid,
    output logic                   partial
);

    logic [23:0] sr;
    logic [1:0]  count;

    assign partial = (count != 2'd0);

    // NOTE: registers use non-blocking assignments so every update reads pre-edge values.
    always_ff @(posedge pclk) begin
        if (!reset_n) begin
            sr         <= '0;
            count      <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                count <= '0;
            end else if (shift_en) begin
                sr    <= {sr[15:0], pixel};
                count <= count + 2'd1;
                if (count == 2'd3) begin
                    word       <= {sr, pixel};
                    word_valid <= 1'b1;
                end
            end else if (flush && partial) begin
                word       <= pad_word(sr, count);
                word_valid <= 1'b1;
                count      <= '0;
            end
        end
    end

endmodule

// File: rtl/i_buf_controller.sv
// Captures a RAW 8-bit video stream into a ping-pong linebuffer, four pixels per word,
// and hands each completed line (and frame) to the PS.
module i_buf_controller
    import i_buf_controller_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = 32,
    parameter int DISPLAY_WIDTH  = DEFAULT_DISPLAY_WIDTH,
    parameter int DISPLAY_HEIGHT = DEFAULT_DISPLAY_HEIGHT
) (
    input  logic                     pclk,
    input  logic                     reset_n,
    input  logic                     vsync,
    input  logic                     href,
    input  logic [PIXEL_WIDTH-1:0]   i_data,
    output logic [ADDRESS_WIDTH-1:0] addr,
    output logic [WORD_WIDTH-1:0]    o_data,
    output logic                     we,
    output logic                     line_ready,
    output logic                     line_bank,
    input  logic                     line_ack,
    output logic [COUNT_WIDTH-1:0]   line_count,
    output logic                     frame_start,
    output logic                     frame_done,
    output logic [1:0]               err
);

    localparam int WORDS_PER_LINE = DISPLAY_WIDTH / 4;
    localparam logic [COUNT_WIDTH-1:0] H_LIMIT = COUNT_WIDTH'(DISPLAY_WIDTH);
    localparam logic [COUNT_WIDTH-1:0] V_LAST  = COUNT_WIDTH'(DISPLAY_HEIGHT - 1);

    logic                   vsync_q, vsync_q2, href_q, href_q2;
    logic [PIXEL_WIDTH-1:0] data_q;
    logic                   vsync_rise, href_rise;

    state_t                 state, state_d;
    logic [COUNT_WIDTH-1:0] h_count, h_count_d, v_count, v_count_d, line_count_d;
    logic                   bank, bank_d, pending, pending_d;
    logic [1:0]             err_d;
    logic                   line_ready_d, line_bank_d, frame_start_d, frame_done_d;
    logic                   shift_en, flush, pk_clear, pk_partial, addr_load;
    logic [ADDRESS_WIDTH-1:0] word_addr;

    assign vsync_rise = vsync_q & ~vsync_q2;
    assign href_rise  = href_q & ~href_q2;
    assign word_addr  = (bank ? ADDRESS_WIDTH'(WORDS_PER_LINE) : '0)
                      + ADDRESS_WIDTH'(h_count >> 2);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d       = state;
        h_count_d     = h_count;
        v_count_d     = v_count;
        bank_d        = bank;
        pending_d     = pending & ~line_ack;
        err_d         = err;
        shift_en      = 1'b0;
        flush         = 1'b0;
        pk_clear      = 1'b0;
        addr_load     = 1'b0;
        line_ready_d  = 1'b0;
        line_bank_d   = line_bank;
        line_count_d  = line_count;
        frame_start_d = 1'b0;
        frame_done_d  = 1'b0;

        // A new frame wins over anything in flight; the partial line is simply dropped.
        if (vsync_rise) begin
            frame_start_d = 1'b1;
            bank_d        = 1'b0;
            v_count_d     = '0;
            h_count_d     = '0;
            pk_clear      = 1'b1;
            state_d       = WAIT_LINE;
        end else begin
            case (state)
                WAIT_FRAME: state_d = WAIT_FRAME;
                WAIT_LINE: begin
                    // The rising-edge cycle already carries pixel 0.
                    if (href_rise) begin
                        shift_en  = 1'b1;
                        h_count_d = COUNT_WIDTH'(1);
                        state_d   = CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (href_q) begin
                        if (h_count < H_LIMIT) begin
                            shift_en  = 1'b1;
                            h_count_d = h_count + COUNT_WIDTH'(1);
                            addr_load = (h_count[1:0] == 2'b11);
                        end
                    end else begin
                        flush     = 1'b1;
                        addr_load = pk_partial;
                        if (h_count < H_LIMIT) err_d[ERR_SHORT_LINE] = 1'b1;
                        state_d = LINE_END;
                    end
                end
                LINE_END: begin
                    line_ready_d = 1'b1;
                    line_bank_d  = bank;
                    line_count_d = v_count;
                    bank_d       = ~bank;
                    v_count_d    = v_count + COUNT_WIDTH'(1);
                    // An ack in this same cycle retires the previous line, so it is not an overrun.
                    if (pending && !line_ack) err_d[ERR_OVERRUN] = 1'b1;
                    pending_d = 1'b1;
                    if (v_count == V_LAST) begin
                        frame_done_d = 1'b1;
                        state_d      = WAIT_FRAME;
                    end else begin
                        state_d = WAIT_LINE;
                    end
                end
                default: state_d = WAIT_FRAME;
            endcase
        end
    end

    always_ff @(posedge pclk) begin
        if (!reset_n) begin
            vsync_q     <= 1'b0;
            vsync_q2    <= 1'b0;
            href_q      <= 1'b0;
            href_q2     <= 1'b0;
            data_q      <= '0;
            state       <= WAIT_FRAME;
            h_count     <= '0;
            v_count     <= '0;
            bank        <= 1'b0;
            pending     <= 1'b0;
            err         <= '0;
            addr        <= '0;
            line_ready  <= 1'b0;
            line_bank   <= 1'b0;
            line_count  <= '0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            vsync_q     <= vsync;
            vsync_q2    <= vsync_q;
            href_q      <= href;
            href_q2     <= href_q;
            data_q      <= i_data;
            state       <= state_d;
            h_count     <= h_count_d;
            v_count     <= v_count_d;
            bank        <= bank_d;
            pending     <= pending_d;
            err         <= err_d;
            if (addr_load) addr <= word_addr;
            line_ready  <= line_ready_d;
            line_bank   <= line_bank_d;
            line_count  <= line_count_d;
            frame_start <= frame_start_d;
            frame_done  <= frame_done_d;
        end
    end

    i_buf_controller_pixel_packer u_packer (
        .pclk       (pclk),
        .reset_n    (reset_n),
        .clear      (pk_clear),
        .shift_en   (shift_en),
        .flush      (flush),
        .pixel      (data_q),
        .word       (o_data),
        .word_valid (we),
        .partial    (pk_partial)
    );

endmodule

// File: tb/tb_i_buf_controller.sv
// Scoreboard bench for i_buf_controller with an 8x2 geometry: stimulus queues expected
// writes, line hand-offs and frame starts; a negedge monitor pops and compares them.
module tb_i_buf_controller;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic        bank;
        logic [12:0] count;
        logic        done;
    } line_t;

    logic        pclk = 1'b0;
    logic        reset_n, vsync, href, line_ack;
    logic [7:0]  i_data;
    logic [31:0] addr, o_data;
    logic        we, line_ready, line_bank, frame_start, frame_done;
    logic [12:0] line_count;
    logic [1:0]  err;

    int    n_vec  = 0;
    int    n_miss = 0;
    int    fs_seen = 0;
    int    fs_issued = 0;
    wr_t   exp_wr[$];
    line_t exp_ln[$];
    int    exp_fs[$];
    wr_t   w;
    line_t l;
    int    f;

    always #5 pclk = ~pclk;

    i_buf_controller #(
        .ADDRESS_WIDTH  (32),
        .DISPLAY_WIDTH  (8),
        .DISPLAY_HEIGHT (2)
    ) dut (
        .pclk        (pclk),
        .reset_n     (reset_n),
        .vsync       (vsync),
        .href        (href),
        .i_data      (i_data),
        .addr        (addr),
        .o_data      (o_data),
        .we          (we),
        .line_ready  (line_ready),
        .line_bank   (line_bank),
        .line_ack    (line_ack),
        .line_count  (line_count),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .err         (err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        n_vec++;
        n_miss++;
        $display("FAIL %s: got %h expected no event", name, act);
    endtask

    always @(negedge pclk) begin
        if (we) begin
            if (exp_wr.size() == 0) unexpected("unexpected_write", addr);
            else begin
                w = exp_wr.pop_front();
                check("write_addr", addr, w.addr);
                check("write_data", o_data, w.data);
            end
        end
        if (line_ready) begin
            if (exp_ln.size() == 0) unexpected("unexpected_line_ready", 32'(line_count));
            else begin
                l = exp_ln.pop_front();
                check("line_bank", 32'(line_bank), 32'(l.bank));
                check("line_count", 32'(line_count), 32'(l.count));
                check("frame_done", 32'(frame_done), 32'(l.done));
            end
        end else if (frame_done) begin
            unexpected("frame_done_without_line", 32'(frame_done));
        end
        if (frame_start) begin
            fs_seen++;
            if (exp_fs.size() == 0) unexpected("unexpected_frame_start", 32'(fs_seen));
            else begin
                f = exp_fs.pop_front();
                check("frame_start_seq", 32'(fs_seen), 32'(f));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected bench completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge pclk);
    endtask

    task automatic exp_write(input logic [31:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_wr.push_back(e);
    endtask

    task automatic exp_line(input logic b, input logic [12:0] c, input logic d);
        line_t e;
        e.bank  = b;
        e.count = c;
        e.done  = d;
        exp_ln.push_back(e);
    endtask

    task automatic raise_vsync();
        fs_issued++;
        exp_fs.push_back(fs_issued);
        vsync = 1'b1;
    endtask

    task automatic start_frame();
        raise_vsync();
        tick(2);
        vsync = 1'b0;
        tick(2);
    endtask

    task automatic drive_line(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            href   = 1'b1;
            i_data = first + 8'(i);
            tick(1);
        end
        href   = 1'b0;
        i_data = '0;
    endtask

    task automatic ack();
        line_ack = 1'b1;
        tick(1);
        line_ack = 1'b0;
    endtask

    task automatic drain(input string tag);
        tick(8);
        check({tag, "_writes_left"}, 32'(exp_wr.size()), 32'd0);
        check({tag, "_lines_left"}, 32'(exp_ln.size()), 32'd0);
        check({tag, "_frames_left"}, 32'(exp_fs.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"}, addr, 32'd0);
        check({tag, "_o_data"}, o_data, 32'd0);
        check({tag, "_we"}, 32'(we), 32'd0);
        check({tag, "_line_ready"}, 32'(line_ready), 32'd0);
        check({tag, "_line_bank"}, 32'(line_bank), 32'd0);
        check({tag, "_line_count"}, 32'(line_count), 32'd0);
        check({tag, "_frame_start"}, 32'(frame_start), 32'd0);
        check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        reset_n  = 1'b0;
        vsync    = 1'b0;
        href     = 1'b0;
        i_data   = '0;
        line_ack = 1'b0;
        tick(3);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        tick(2);

        // Two full lines with acks: bank 0 then bank 1, frame_done on the second.
        start_frame();
        exp_write(32'd0, 32'h01020304);
        exp_write(32'd1, 32'h05060708);
        exp_line(1'b0, 13'd0, 1'b0);
        drive_line(8'h01, 8);
        tick(6);
        ack();
        exp_write(32'd2, 32'h01020304);
        exp_write(32'd3, 32'h05060708);
        exp_line(1'b1, 13'd1, 1'b1);
        drive_line(8'h01, 8);
        tick(6);
        ack();
        drain("full_frame");
        check("full_frame_err", 32'(err), 32'd0);

        // Short line of 6 pixels: zero-padded flush, short-line error.
        start_frame();
        exp_write(32'd0, 32'h01020304);
        exp_write(32'd1, 32'h05060000);
        exp_line(1'b0, 13'd0, 1'b0);
        drive_line(8'h01, 6);
        tick(6);
        check("short_line_err", 32'(err), 32'd2);
        ack();

        // Long line of 10 pixels: pixels past the width are dropped.
        exp_write(32'd2, 32'h01020304);
        exp_write(32'd3, 32'h05060708);
        exp_line(1'b1, 13'd1, 1'b1);
        drive_line(8'h01, 10);
        tick(6);
        ack();
        drain("long_line");

        // vsync rises after 5 pixels: one write, no line hand-off, restart in bank 0.
        start_frame();
        exp_write(32'd0, 32'h01020304);
        drive_line(8'h01, 5);
        raise_vsync();
        tick(2);
        vsync = 1'b0;
        tick(4);
        drain("abort");
        check("abort_err", 32'(err), 32'd2);
        exp_write(32'd0, 32'h11121314);
        exp_write(32'd1, 32'h15161718);
        exp_line(1'b0, 13'd0, 1'b0);
        drive_line(8'h11, 8);
        tick(6);
        check("before_overrun_err", 32'(err), 32'd2);

        // Second line with the first still unacknowledged: overrun flagged.
        exp_write(32'd2, 32'h21222324);
        exp_write(32'd3, 32'h25262728);
        exp_line(1'b1, 13'd1, 1'b1);
        drive_line(8'h21, 8);
        tick(6);
        drain("overrun");
        check("overrun_err", 32'(err), 32'd3);
        check("overrun_line_bank", 32'(line_bank), 32'd1);
        ack();

        // One-cycle reset in mid-capture clears everything; writes need a fresh vsync.
        start_frame();
        drive_line(8'h01, 3);
        href    = 1'b1;
        i_data  = 8'h04;
        reset_n = 1'b0;
        tick(1);
        check_reset_outputs("mid_reset");
        reset_n = 1'b1;
        drive_line(8'h05, 4);
        tick(4);
        drive_line(8'h41, 8);
        tick(6);
        drain("post_reset_idle");
        start_frame();
        exp_write(32'd0, 32'h31323334);
        exp_write(32'd1, 32'h35363738);
        exp_line(1'b0, 13'd0, 1'b0);
        drive_line(8'h31, 8);
        tick(6);
        drain("post_reset_frame");
        check("post_reset_err", 32'(err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
